// File: rtl/alu_operand_sequencer.sv
// Operand entry front-end for the 4-op ALU: debounces the confirm button, sequences
// A / B / opcode entry from a shared switch bus, then captures the ALU result and status.
module alu_operand_sequencer #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [N-1:0] i_data,
  input  logic         i_enter,
  input  logic         i_clear,
  input  logic [N-1:0] i_result,
  input  logic [3:0]   i_status,
  output logic [N-1:0] o_a,
  output logic [N-1:0] o_b,
  output logic [1:0]   o_opcode,
  output logic [N-1:0] o_result,
  output logic [3:0]   o_status,
  output logic [2:0]   o_state,
  output logic [N-1:0] o_display,
  output logic         o_done
);

  // state  | meaning
  // S_A    | waiting for operand A
  // S_B    | waiting for operand B
  // S_OP   | waiting for opcode
  // S_EXEC | operands stable, capture ALU result
  // S_SHOW | result on display until next press
  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d, deb_dly_q;
  logic          pulse_q;
  logic          armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rel_cnt_q, rel_cnt_d;

  state_t        state_q;
  logic [N-1:0]  a_q, b_q, result_q;
  logic [1:0]    opcode_q;
  logic [3:0]    status_q;

  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) deb_d = sync2_q;
      else                   cnt_d = cnt_q + CW'(1);
    end
  end

  // After reset the button must be seen released for a full debounce window
  // before any press is honoured, so a press held through reset never fires.
  always_comb begin
    armed_d   = armed_q;
    rel_cnt_d = '0;
    if (!armed_q && !sync2_q && !deb_q) begin
      if (rel_cnt_q == CNT_LAST) armed_d   = 1'b1;
      else                       rel_cnt_d = rel_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      pulse_q   <= 1'b0;
      armed_q   <= 1'b0;
      rel_cnt_q <= '0;
    end else begin
      sync1_q   <= i_enter;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      pulse_q   <= armed_q & deb_q & ~deb_dly_q;
      armed_q   <= armed_d;
      rel_cnt_q <= rel_cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      state_q  <= S_A;
      a_q      <= '0;
      b_q      <= '0;
      opcode_q <= '0;
      result_q <= '0;
      status_q <= '0;
    end else begin
      case (state_q)
        S_A: if (pulse_q) begin
          a_q     <= i_data;
          state_q <= S_B;
        end
        S_B: if (pulse_q) begin
          b_q     <= i_data;
          state_q <= S_OP;
        end
        S_OP: if (pulse_q) begin
          opcode_q <= i_data[1:0];
          state_q  <= S_EXEC;
        end
        S_EXEC: begin
          result_q <= i_result;
          status_q <= i_status;
          state_q  <= S_SHOW;
        end
        S_SHOW: if (pulse_q) state_q <= S_A;
        default: state_q <= S_A;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      S_A, S_B: o_display = i_data;
      S_OP:     o_display = N'(i_data[1:0]);
      default:  o_display = result_q;
    endcase
  end

  assign o_a      = a_q;
  assign o_b      = b_q;
  assign o_opcode = opcode_q;
  assign o_result = result_q;
  assign o_status = status_q;
  assign o_state  = state_q;
  assign o_done   = (state_q == S_SHOW);

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a small behavioural ALU stub
// and hand-computed expectations.
module tb_alu_operand_sequencer;
  localparam int N   = 4;
  localparam int DEB = 4;

  logic         i_clk = 1'b0;
  logic         i_reset, i_enter, i_clear;
  logic [N-1:0] i_data, i_result;
  logic [3:0]   i_status;
  logic [N-1:0] o_a, o_b, o_result, o_display;
  logic [1:0]   o_opcode;
  logic [3:0]   o_status;
  logic [2:0]   o_state;
  logic         o_done;

  int err_cnt = 0;
  int chk_cnt = 0;

  alu_operand_sequencer #(.N(N), .DEBOUNCE_CYCLES(DEB)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_enter(i_enter),
    .i_clear(i_clear), .i_result(i_result), .i_status(i_status),
    .o_a(o_a), .o_b(o_b), .o_opcode(o_opcode), .o_result(o_result),
    .o_status(o_status), .o_state(o_state), .o_display(o_display), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  // ALU stub: 0 add, 1 sub, 2 and, 3 or; status {N,Z,C,V}
  logic [N:0] alu_tmp;
  logic       alu_c, alu_v;
  always_comb begin
    alu_tmp = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (o_opcode)
      2'd0: begin
        alu_tmp = {1'b0, o_a} + {1'b0, o_b};
        alu_c   = alu_tmp[N];
        alu_v   = (o_a[N-1] == o_b[N-1]) && (alu_tmp[N-1] != o_a[N-1]);
      end
      2'd1: begin
        alu_tmp = {1'b0, o_a} - {1'b0, o_b};
        alu_c   = (o_a >= o_b);
        alu_v   = (o_a[N-1] != o_b[N-1]) && (alu_tmp[N-1] != o_a[N-1]);
      end
      2'd2:    alu_tmp = {1'b0, o_a & o_b};
      default: alu_tmp = {1'b0, o_a | o_b};
    endcase
    i_result = alu_tmp[N-1:0];
    i_status = {alu_tmp[N-1], (alu_tmp[N-1:0] == '0), alu_c, alu_v};
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Press and hold until the state moves (bounded), then release and let it settle.
  task automatic press(input logic [N-1:0] d, input logic [2:0] exp_state, input string tag);
    logic [2:0] s0;
    int n;
    i_data  = d;
    s0      = o_state;
    i_enter = 1'b1;
    n       = 0;
    while (o_state == s0 && n < 30) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(o_state), 32'(exp_state));
    repeat (5) tick();
    i_enter = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    logic [2:0] prev;
    int trans, lat;

    i_reset = 1'b1; i_enter = 1'b0; i_clear = 1'b0; i_data = 4'd5;

    // 1: reset
    repeat (3) tick();
    i_reset = 1'b0;
    check_eq("rst_state", 32'(o_state), 0);
    check_eq("rst_regs", {o_a, o_b, o_opcode, o_result, o_status}, 0);
    check_eq("rst_done", 32'(o_done), 0);
    check_eq("rst_display", 32'(o_display), 5);
    repeat (10) tick();

    // 3: bounce shorter than the debounce window is ignored
    for (int c = 0; c < 20; c++) begin
      i_enter = ((c / 2) % 2) == 0;
      tick();
    end
    i_enter = 1'b0;
    repeat (8) tick();
    check_eq("bounce_state", 32'(o_state), 0);

    i_data  = 4'd3;
    i_enter = 1'b1;
    prev = o_state; trans = 0; lat = -1;
    for (int n = 1; n <= 50; n++) begin
      tick();
      if (o_state != prev) begin
        if (trans == 0) lat = n - 1;
        trans++;
      end
      prev = o_state;
    end
    check_eq("hold_latency", 32'(lat), DEB + 3);
    check_eq("hold_transitions", 32'(trans), 1);
    check_eq("hold_state", 32'(o_state), 1);
    i_enter = 1'b0;
    repeat (12) tick();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    check_eq("clear_in_b", 32'(o_state), 0);
    check_eq("clear_a", 32'(o_a), 0);

    // 2: full entry 7 + 1 with opcode 0
    press(4'd7, 3'd1, "enter_a");
    press(4'd1, 3'd2, "enter_b");
    press(4'd0, 3'd3, "enter_op");
    check_eq("show_state", 32'(o_state), 4);
    check_eq("show_a", 32'(o_a), 7);
    check_eq("show_b", 32'(o_b), 1);
    check_eq("show_op", 32'(o_opcode), 0);
    check_eq("show_result", 32'(o_result), 8);
    check_eq("show_status", 32'(o_status), 32'b1001);
    check_eq("show_done", 32'(o_done), 1);
    check_eq("show_display", 32'(o_display), 8);

    // 5: wrap back to entry, old result retained until the next execution
    press(4'd0, 3'd0, "wrap");
    check_eq("wrap_result", 32'(o_result), 8);
    check_eq("wrap_done", 32'(o_done), 0);
    i_data = 4'd6;
    #1 check_eq("disp_live_a", 32'(o_display), 6);
    press(4'd15, 3'd1, "enter_a2");
    i_data = 4'd3;
    repeat (3) tick();
    check_eq("a_stable", 32'(o_a), 15);
    press(4'd15, 3'd2, "enter_b2");
    i_data = 4'b1110;
    #1 check_eq("disp_op", 32'(o_display), 2);
    check_eq("result_held_op", 32'(o_result), 8);
    press(4'd3, 3'd3, "enter_op2");
    check_eq("op2_vals", {o_a, o_b, o_opcode}, {4'd15, 4'd15, 2'd3});
    check_eq("op2_result", 32'(o_result), 15);
    check_eq("op2_status", 32'(o_status), 32'b1000);

    // 4: clear coinciding with enter_pulse in S_OP
    press(4'd0, 3'd0, "wrap2");
    press(4'd4, 3'd1, "enter_a3");
    press(4'd12, 3'd2, "enter_b3");
    check_eq("pre_clear_ab", {o_a, o_b}, {4'd4, 4'd12});
    i_data  = 4'd1;
    i_enter = 1'b1;
    repeat (DEB + 3) tick();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    check_eq("clear_state", 32'(o_state), 0);
    check_eq("clear_regs", {o_a, o_b, o_opcode}, 0);
    repeat (5) tick();
    check_eq("clear_no_exec", 32'(o_state), 0);
    i_enter = 1'b0;
    repeat (12) tick();

    // 6: reset during a held press
    i_data  = 4'd9;
    i_enter = 1'b1;
    repeat (2) tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check_eq("rst6_state", 32'(o_state), 0);
    repeat (30) tick();
    check_eq("rst6_held", 32'(o_state), 0);
    i_enter = 1'b0;
    repeat (15) tick();
    check_eq("rst6_released", 32'(o_state), 0);
    press(4'd9, 3'd1, "rst6_repress");
    check_eq("rst6_a", 32'(o_a), 9);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
